// File: rtl/alu_result_skid.sv
// alu_result_skid: two-entry skid buffer registering ALU/shifter results with N/Z/C/V status toward write-back
module alu_result_skid #(
    parameter int         WIDTH = 32,
    parameter logic [4:0] ROT_L = 5'h1A,
    parameter logic [4:0] ROT_R = 5'h1B
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_FS,
    input  logic [WIDTH-1:0] in_Y_hi,
    input  logic [WIDTH-1:0] in_Y_lo,
    input  logic             in_C,
    input  logic             in_V,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_FS,
    output logic [WIDTH-1:0] out_Y_hi,
    output logic [WIDTH-1:0] out_Y_lo,
    output logic             out_C,
    output logic             out_V,
    output logic             out_N,
    output logic             out_Z
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    typedef struct packed {
        logic [4:0]       fs;
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             c;
        logic             v;
        logic             n;
        logic             z;
    } entry_t;

    state_t state;
    entry_t head, tail, cap;
    logic   en, push, pop, rot;

    // rotates carry no meaningful C/V from the shifter, so they are cleared at capture
    assign rot       = (in_FS == ROT_L) || (in_FS == ROT_R);
    assign cap       = {in_FS, in_Y_hi, in_Y_lo, in_C & ~rot, in_V & ~rot, in_Y_lo[WIDTH-1], in_Y_lo == '0};
    assign in_ready  = en & (state != FULL) & ~flush;
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign {out_FS, out_Y_hi, out_Y_lo, out_C, out_V, out_N, out_Z} = head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
            en    <= 1'b0;
        end else begin
            en <= 1'b1;
            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: if (push) begin
                        head  <= cap;
                        state <= ONE;
                    end
                    ONE: if (push && pop) begin
                        head <= cap;
                    end else if (push) begin
                        tail  <= cap;
                        state <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                    FULL: if (pop) begin
                        head  <= tail;
                        state <= ONE;
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_result_skid.sv
// tb_alu_result_skid: scoreboard bench for the ALU result skid buffer
module tb_alu_result_skid;
    localparam int W = 32;

    logic         clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0, in_C = 0, in_V = 0;
    logic [4:0]   in_FS = 0;
    logic [W-1:0] in_Y_hi = 0, in_Y_lo = 0;
    logic         in_ready, out_valid, out_C, out_V, out_N, out_Z;
    logic [4:0]   out_FS;
    logic [W-1:0] out_Y_hi, out_Y_lo;

    alu_result_skid #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_FS(in_FS),
        .in_Y_hi(in_Y_hi), .in_Y_lo(in_Y_lo), .in_C(in_C), .in_V(in_V),
        .out_valid(out_valid), .out_ready(out_ready), .out_FS(out_FS),
        .out_Y_hi(out_Y_hi), .out_Y_lo(out_Y_lo),
        .out_C(out_C), .out_V(out_V), .out_N(out_N), .out_Z(out_Z)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]   fs;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         c, v, n, z;
    } ent_t;

    ent_t q[$];
    int   n_chk = 0, n_bad = 0;
    logic en_m = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ent_t model(input logic [4:0] fs, input logic [W-1:0] hi, lo, input logic c, v);
        logic r;
        r = (fs == 5'h1A) || (fs == 5'h1B);
        return '{fs: fs, hi: hi, lo: lo, c: r ? 1'b0 : c, v: r ? 1'b0 : v, n: lo[W-1], z: (lo == 0)};
    endfunction

    task automatic put(input logic vld, input logic [4:0] fs, input logic [W-1:0] hi, lo, input logic c, v);
        in_valid = vld; in_FS = fs; in_Y_hi = hi; in_Y_lo = lo; in_C = c; in_V = v;
    endtask

    function automatic logic [79:0] outs();
        return 80'({out_FS, out_Y_hi, out_Y_lo, out_C, out_V, out_N, out_Z});
    endfunction

    // called just after a negedge with inputs already driven; accounts for the coming posedge
    task automatic tick();
        ent_t e;
        #1;
        check("ovalid", 80'(out_valid), 80'(q.size() != 0));
        check("irdy", 80'(in_ready), 80'(en_m && q.size() < 2 && !flush));
        if (out_valid && out_ready) begin
            check("sb_avail", 80'(q.size() != 0), 80'(1));
            if (q.size() != 0) begin
                e = q.pop_front();
                check("head", outs(), 80'(e));
            end
        end
        if (in_valid && in_ready) q.push_back(model(in_FS, in_Y_hi, in_Y_lo, in_C, in_V));
        if (flush) q.delete();
        @(negedge clk);
        if (reset) en_m = 1;
    endtask

    initial begin
        logic [4:0] fs;
        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_rdy", 80'(in_ready), 80'(0));
            check("rst_val", 80'(out_valid), 80'(0));
            check("rst_out", outs(), 80'(0));
        end
        reset = 1;
        #1 check("rdy_pre_edge", 80'(in_ready), 80'(0));
        tick();
        check("rdy_after_rel", 80'(in_ready), 80'(1));

        // single rotate push: Z=1, C/V cleared
        out_ready = 1;
        put(1, 5'h1A, 32'h1234_5678, 32'h0, 1, 1);
        tick();
        put(0, 0, 0, 0, 0, 0);
        check("single_val", 80'(out_valid), 80'(1));
        check("single_flags", 80'({out_Z, out_N, out_C, out_V}), 80'(4'b1000));
        tick();
        check("single_empty", 80'(out_valid), 80'(0));

        // backpressure fills both entries
        out_ready = 0;
        put(1, 5'h03, 32'hAAAA_0000, 32'h8000_0001, 1, 0);
        tick();
        put(1, 5'h04, 32'hBBBB_0000, 32'h0000_0002, 0, 1);
        tick();
        put(1, 5'h05, 32'hCCCC_0000, 32'h0000_0003, 1, 1);
        #1 check("bp_full_rdy", 80'(in_ready), 80'(0));
        check("bp_head_n", 80'({out_Y_lo, out_N}), 80'({32'h8000_0001, 1'b1}));
        tick();
        put(0, 0, 0, 0, 0, 0);
        out_ready = 1;
        tick();
        check("bp_rdy_back", 80'(in_ready), 80'(1));
        check("bp_second", 80'(out_Y_lo), 80'(32'h2));
        tick();
        check("bp_drained", 80'(out_valid), 80'(0));

        // streaming one result per cycle
        for (int i = 1; i <= 10; i++) begin
            put(1, 5'(i), 32'(i * 7), 32'(i), 1'(i), 1'(i >> 1));
            tick();
        end
        put(0, 0, 0, 0, 0, 0);
        tick();
        tick();

        // flush while full, with a presented input
        out_ready = 0;
        put(1, 5'h06, 32'h1, 32'h11, 0, 0);
        tick();
        put(1, 5'h07, 32'h2, 32'h22, 0, 0);
        tick();
        put(1, 5'h08, 32'h3, 32'h33, 1, 1);
        flush = 1;
        tick();
        flush = 0;
        put(0, 0, 0, 0, 0, 0);
        #1 check("flush_val", 80'(out_valid), 80'(0));
        check("flush_rdy", 80'(in_ready), 80'(1));
        tick();

        // randomized traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            fs = ($urandom_range(0, 3) == 0) ? (5'h1A | 5'($urandom_range(0, 1))) : 5'($urandom);
            put(1'($urandom_range(0, 2) != 0), fs, $urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
                1'($urandom), 1'($urandom));
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 29) == 0);
            tick();
        end
        flush = 0;

        // async reset while full
        out_ready = 0;
        put(1, 5'h09, 32'h9, 32'h99, 1, 0);
        tick();
        put(1, 5'h0A, 32'hA, 32'hAA, 0, 1);
        tick();
        put(0, 0, 0, 0, 0, 0);
        check("pre_arst_val", 80'(out_valid), 80'(1));
        #2 reset = 0;
        #1 check("arst_val", 80'(out_valid), 80'(0));
        check("arst_out", outs(), 80'(0));
        q.delete();
        en_m = 0;
        @(negedge clk);
        reset = 1;
        tick();
        check("post_arst_val", 80'(out_valid), 80'(0));
        check("post_arst_rdy", 80'(in_ready), 80'(1));
        out_ready = 1;
        put(1, 5'h0B, 32'hB, 32'hBB, 1, 1);
        tick();
        put(0, 0, 0, 0, 0, 0);
        tick();
        check("end_empty", 80'(q.size()), 80'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_result_skid.md
Name: alu_result_skid

Overview:
- Registered output stage directly downstream of the integer ALU/barrel-shifter result mux.
- Captures the execute-stage result pair (Y_hi, Y_lo), its function select and its carry/overflow.
- Derives N/Z status and buffers up to two results in a skid buffer with a valid/ready handshake toward write-back.
- Lets write-back stall without dropping a result already produced by the combinational shifter/ALU.

Parameters:
- WIDTH, 32, datapath width of Y_hi/Y_lo.
- ROT_L, 5'h1A, FS code for rotate left.
- ROT_R, 5'h1B, FS code for rotate right.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous buffer clear (pipeline squash)
- in_valid  input  1  execute result valid
- in_ready  output  1  stage can accept a result this cycle
- in_FS  input  5  function select of the result
- in_Y_hi  input  WIDTH  upper result word
- in_Y_lo  input  WIDTH  lower result word
- in_C  input  1  carry from ALU
- in_V  input  1  overflow from ALU
- out_valid  output  1  head entry valid
- out_ready  input  1  write-back accepts head
- out_FS  output  5  head function select
- out_Y_hi  output  WIDTH  head upper word
- out_Y_lo  output  WIDTH  head lower word
- out_C, out_V, out_N, out_Z  output  1 each  head status flags

Behaviour:
- Reset (reset=0, asynchronous):
  - occupancy=0; all data and flag outputs=0; out_valid=0.
  - in_ready=0 while reset is low; goes 1 on the first clk edge after release (registered enable).
- Storage: two entries, HEAD and TAIL. Occupancy register 0..2; states EMPTY, ONE, FULL.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - out_valid = (occupancy != 0).
  - in_ready = enable & (occupancy != 2) & ~flush.
- Capture per entry:
  - FS, Y_hi, Y_lo stored as given.
  - N = in_Y_lo[WIDTH-1].
  - Z = (in_Y_lo == 0), i.e. Z covers Y_lo only.
  - C/V stored as in_C/in_V, except forced to 0 when in_FS is ROT_L or ROT_R.
- Transitions (evaluated at clk edge):
  - EMPTY + push -> ONE; HEAD <= input.
  - ONE + push, no pop -> FULL; TAIL <= input.
  - ONE + pop, no push -> EMPTY.
  - ONE + push + pop -> ONE; HEAD <= input.
  - FULL + pop -> ONE; HEAD <= TAIL. No push is possible in FULL (in_ready=0).
  - No push/pop: hold state and contents.
- Latency: a result pushed at edge t is visible on out_* after edge t (one cycle) when the buffer was EMPTY.
- Ordering: strict FIFO. out_* reflect HEAD and stay stable while out_valid=1 and out_ready=0.
- flush=1 at an edge:
  - occupancy <= 0 regardless of push/pop.
  - in_ready is low in that cycle, so no push is taken.
  - Entry contents may be left stale; out_valid=0 next cycle.
- Simultaneous pop and flush: flush wins; the pop is considered taken by the consumer, and no data is re-presented.
- Outputs when out_valid=0: hold last HEAD value (no X). After reset they are 0.
- Reset asserted mid-transfer: state cleared immediately and asynchronously; no partial entries survive.
- No combinational path from out_ready to in_ready; in_ready depends only on registers and flush.

Test Plan:
- Reset then idle: reset low for 3 cycles.
  - During reset: in_ready=0, out_valid=0, all outputs 0.
  - First edge after release: in_ready=1.
- Single push: FS=5'h1A, Y_lo=32'h0000_0000, C=1, V=1, out_ready=1.
  - Next cycle: out_valid=1, out_Z=1, out_N=0, out_C=0, out_V=0.
  - Following cycle: out_valid=0.
- Backpressure: out_ready=0; push Y_lo=32'h8000_0001 then 32'h0000_0002.
  - in_ready=0 after the second push.
  - A third in_valid is not accepted.
  - Raise out_ready: results emerge in order 8000_0001 (N=1) then 0000_0002; in_ready returns to 1 after the first pop.
- Streaming: in_valid=1 and out_ready=1 every cycle with Y_lo=1,2,3,…,10.
  - Occupancy stays ONE; outputs appear one per cycle, in order, one cycle late.
- Flush while FULL: two entries stored, flush=1 for one cycle with in_valid=1.
  - Next cycle: out_valid=0; the presented input is not captured; in_ready=1.
- Async reset mid-operation: FULL state, drop reset between clock edges.
  - out_valid=0 immediately (before the next edge); buffer empty after release.
